rx_packet_ctrl: RTL and testbench
=================================

// Module: rx_packet_ctrl
// PURPOSE
//  Sequences the serial byte receiver (start detect / bit counters / SIPO) into framed packets.
//  Each receiver byte (rx_data qualified by a 1-cycle rx_finish pulse) is parsed as SYNC, LEN,
//  LEN payload bytes, then CHK. Payload is written tentatively into a commit/rollback FIFO.
//  Only checksum-verified packets become visible to the consumer via a valid/ready interface.
// PARAMETERS
//  DEPTH    16     FIFO entries; power of 2, >= MAX_LEN
//  MAX_LEN  8      largest legal LEN value (1..MAX_LEN accepted)
//  SYNC     8'h7E  frame start byte
//  TIMEOUT  4096   max clk cycles between consecutive bytes inside a frame
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high
//  rx_data    in   8  byte from receiver SIPO
//  rx_finish  in   1  1-cycle pulse: rx_data valid this cycle
//  out_data   out  8  payload byte at FIFO head
//  out_last   out  1  head byte is last byte of its packet
//  out_valid  out  1  committed byte available
//  out_ready  in   1  consumer accepts; pop when out_valid & out_ready
//  pkt_ok     out  1  1-cycle pulse: packet committed
//  pkt_err    out  1  1-cycle pulse: packet discarded
//  err_code   out  2  0=checksum 1=bad length 2=overflow 3=timeout; held until next pkt_err
//  busy       out  1  state != HUNT
// BEHAVIOUR
//  Reset: state=HUNT, FIFO empty (rd=wr=commit=0), timer=0; all outputs 0, out_data=0.
//  FSM, advancing only on rx_finish unless noted:
//   HUNT:    byte==SYNC -> LEN; any other byte ignored, no error.
//   LEN:     1<=byte<=MAX_LEN -> latch len, chk=byte, cnt=0 -> PAYLOAD;
//            else pkt_err, code 1 -> HUNT.
//   PAYLOAD: if FIFO full (wr-rd==DEPTH) -> rollback, pkt_err code 2 -> HUNT;
//            else write {cnt==len-1, byte} at wr, wr++, chk^=byte; cnt==len-1 -> CHECK.
//   CHECK:   byte==chk -> commit=wr, pkt_ok; else rollback (wr=commit), pkt_err code 0.
//            Either way -> HUNT.
//  Checksum: 8-bit XOR of LEN and all payload bytes.
//  Timeout: timer clears on every rx_finish and in HUNT, else increments.
//   Reaching TIMEOUT in LEN/PAYLOAD/CHECK with no rx_finish that cycle -> rollback,
//   pkt_err code 3, HUNT. A byte arriving on the expiry cycle wins.
//  Pointers are log2(DEPTH)+1 bits; wrap by natural overflow.
//   Full = wr-rd==DEPTH, counting uncommitted entries.
//  out_valid = (rd != commit); out_data/out_last come from the entry at rd.
//   Uncommitted bytes are never visible.
//  Latency: pkt_ok is asserted in the cycle after the CHK rx_finish. out_valid rises in the
//   same cycle when the FIFO was empty.
//  Simultaneous pop and push/commit are legal and independent.
//   Rollback never moves rd; rd <= commit always holds.
//  SYNC byte value inside LEN/PAYLOAD/CHECK is data, not a restart.
//  reset mid-packet: the whole FIFO, including committed but unread data, is cleared.
// STRUCTURE
//  Package rx_packet_pkg: state_t enum {HUNT,LEN,PAYLOAD,CHECK}; err_t codes; SYNC_DEFAULT.
//  Sub-module pkt_fifo: 9-bit-wide storage with wr/commit/rd pointers and
//   push/commit/rollback/pop controls, exporting full/valid.
//  rx_packet_ctrl holds the FSM, length counter, checksum register and timeout timer.
// TESTING
//  1 Bytes 7E 03 11 22 33 03 -> pkt_ok; with ready=1 consumer gets 11,22,33.
//    out_last is set only on 33; err_code unchanged.
//  2 Same frame with CHK 04 -> pkt_err, err_code 0; out_valid never rises.
//    A following good frame delivers correctly.
//  3 7E 00 and 7E 09 (MAX_LEN=8) -> pkt_err code 1 each; next byte is treated in HUNT.
//  4 DEPTH=4, ready=0: 7E 05 + 5 bytes -> 5th payload byte gives pkt_err code 2.
//    FIFO stays empty; an earlier committed 2-byte packet is still delivered intact.
//  5 7E 02 AA, then silence TIMEOUT cycles -> pkt_err code 3, busy=0.
//    A byte landing exactly on the expiry cycle is accepted instead.
//  6 Backpressure with ready toggling every cycle across two back-to-back packets:
//    all bytes in order, none lost or duplicated.
//    Reset asserted mid-PAYLOAD -> outputs 0, out_valid=0 next cycle.

Source files
------------

// File: rtl/rx_packet_pkg.sv
// Shared types for the packet receiver.
//   state_t      : framing FSM states
//   err_t        : error codes reported on err_code
//   SYNC_DEFAULT : default frame start byte
package rx_packet_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_CHECKSUM = 2'd0,
    ERR_LENGTH   = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;

endpackage

// File: rtl/pkt_fifo.sv
// Commit/rollback FIFO holding {last, data} entries.
// Writes are tentative until commit; rollback discards everything written
// since the last commit. The reader only sees committed entries.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   push/push_data : write one 9-bit entry at wr
//   commit         : publish all written entries (commit <= wr)
//   rollback       : discard uncommitted entries (wr <= commit)
//   pop            : advance rd (caller only pops when valid)
//   full           : wr - rd == DEPTH (uncommitted entries count too)
//   valid          : at least one committed, unread entry
//   head           : entry at rd
module pkt_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [8:0] push_data,
  input  logic       commit,
  input  logic       rollback,
  input  logic       pop,
  output logic       full,
  output logic       valid,
  output logic [8:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] commit_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;

  // Storage carries no reset; the head is masked by valid at the top level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Pointers wrap naturally; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      if (rollback) begin
        wr_ptr_reg <= commit_ptr_reg;
      end else if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (commit) begin
        commit_ptr_reg <= wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  assign full  = (wr_ptr_reg - rd_ptr_reg) == DEPTH_P;
  assign valid = rd_ptr_reg != commit_ptr_reg;
  assign head  = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/rx_packet_ctrl.sv
// Frames receiver bytes into SYNC, LEN, payload, CHK packets. Payload is
// written tentatively into pkt_fifo and only committed when the XOR
// checksum (LEN ^ payload bytes) matches CHK.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   rx_data, rx_finish  : received byte and its 1-cycle qualifier
//   out_data, out_last  : committed head byte and end-of-packet flag
//   out_valid/out_ready : consumer handshake; pop on both high
//   pkt_ok, pkt_err     : 1-cycle pulses for commit / discard
//   err_code            : reason of the most recent discard
//   busy                : a frame is being received
module rx_packet_ctrl
  import rx_packet_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter int         MAX_LEN = 8,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_finish,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_reg, state_next;
  logic [7:0]    len_reg, len_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic [7:0]    chk_reg, chk_next;
  logic [TW-1:0] timer_reg;
  logic          pkt_ok_reg, pkt_ok_next;
  logic          pkt_err_reg, pkt_err_next;
  logic [1:0]    err_code_reg, err_code_next;

  logic       fifo_push, fifo_commit, fifo_rollback, fifo_pop;
  logic       fifo_full, fifo_valid;
  logic [8:0] fifo_head;
  logic       timed_out;

  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign timed_out = (state_reg != HUNT) && (timer_reg == TW'(TIMEOUT)) && !rx_finish;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= HUNT;
      len_reg      <= '0;
      cnt_reg      <= '0;
      chk_reg      <= '0;
      pkt_ok_reg   <= 1'b0;
      pkt_err_reg  <= 1'b0;
      err_code_reg <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      cnt_reg      <= cnt_next;
      chk_reg      <= chk_next;
      pkt_ok_reg   <= pkt_ok_next;
      pkt_err_reg  <= pkt_err_next;
      err_code_reg <= err_code_next;
    end
  end

  // Inter-byte timer; saturates so it cannot wrap past the expiry value.
  always_ff @(posedge clk) begin
    if (reset || rx_finish || state_reg == HUNT) begin
      timer_reg <= '0;
    end else if (timer_reg != TW'(TIMEOUT)) begin
      timer_reg <= timer_reg + TW'(1);
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    cnt_next      = cnt_reg;
    chk_next      = chk_reg;
    pkt_ok_next   = 1'b0;
    pkt_err_next  = 1'b0;
    err_code_next = err_code_reg;
    fifo_push     = 1'b0;
    fifo_commit   = 1'b0;
    fifo_rollback = 1'b0;

    case (state_reg)
      HUNT: begin
        if (rx_finish && rx_data == SYNC) begin
          state_next = LEN;
        end
      end
      LEN: begin
        if (rx_finish) begin
          if (rx_data != 8'd0 && rx_data <= 8'(MAX_LEN)) begin
            len_next   = rx_data;
            chk_next   = rx_data;
            cnt_next   = 8'd0;
            state_next = PAYLOAD;
          end else begin
            pkt_err_next  = 1'b1;
            err_code_next = ERR_LENGTH;
            state_next    = HUNT;
          end
        end
      end
      PAYLOAD: begin
        if (rx_finish) begin
          if (fifo_full) begin
            fifo_rollback = 1'b1;
            pkt_err_next  = 1'b1;
            err_code_next = ERR_OVERFLOW;
            state_next    = HUNT;
          end else begin
            fifo_push = 1'b1;
            chk_next  = chk_reg ^ rx_data;
            cnt_next  = cnt_reg + 8'd1;
            if (cnt_reg == len_reg - 8'd1) begin
              state_next = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (rx_finish) begin
          if (rx_data == chk_reg) begin
            fifo_commit = 1'b1;
            pkt_ok_next = 1'b1;
          end else begin
            fifo_rollback = 1'b1;
            pkt_err_next  = 1'b1;
            err_code_next = ERR_CHECKSUM;
          end
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase

    if (timed_out) begin
      fifo_rollback = 1'b1;
      pkt_err_next  = 1'b1;
      err_code_next = ERR_TIMEOUT;
      state_next    = HUNT;
    end
  end

  assign fifo_pop = fifo_valid && out_ready;

  pkt_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data({cnt_reg == len_reg - 8'd1, rx_data}),
    .commit   (fifo_commit),
    .rollback (fifo_rollback),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .valid    (fifo_valid),
    .head     (fifo_head)
  );

  // Head is masked when nothing is committed so unwritten RAM never leaks out.
  assign out_valid = fifo_valid;
  assign out_data  = fifo_valid ? fifo_head[7:0] : 8'd0;
  assign out_last  = fifo_valid & fifo_head[8];
  assign pkt_ok    = pkt_ok_reg;
  assign pkt_err   = pkt_err_reg;
  assign err_code  = err_code_reg;
  assign busy      = state_reg != HUNT;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
module tb_rx_packet_ctrl;

  localparam int         DEPTH   = 4;
  localparam int         MAX_LEN = 8;
  localparam int         TIMEOUT = 64;
  localparam logic [7:0] SYNC    = 8'h7E;

  logic       clk, reset, rx_finish, out_ready;
  logic [7:0] rx_data, out_data;
  logic       out_last, out_valid, pkt_ok, pkt_err, busy;
  logic [1:0] err_code;

  int total, bad;

  rx_packet_ctrl #(
    .DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .SYNC(SYNC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_finish(rx_finish),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (queues, spec-level rules) -------------
  logic [8:0] m_commit[$];   // committed {last,data}, visible to consumer
  logic [7:0] m_pend[$];     // payload of the frame in progress
  bit         m_in_frame;
  int         m_len;         // 0 while waiting for the LEN byte
  int         m_idle;
  bit         m_ok, m_err;
  logic [1:0] m_code;

  task automatic model_abort(input logic [1:0] code);
    m_pend.delete();
    m_in_frame = 0;
    m_len      = 0;
    m_err      = 1;
    m_code     = code;
  endtask

  task automatic model_step(input bit rst, input bit fin, input logic [7:0] d, input bit rdy);
    bit         do_pop;
    int         occupied;
    logic [7:0] x;
    if (rst) begin
      m_commit.delete(); m_pend.delete();
      m_in_frame = 0; m_len = 0; m_idle = 0;
      m_ok = 0; m_err = 0; m_code = 0;
      return;
    end
    do_pop   = (m_commit.size() > 0) && rdy;
    occupied = m_commit.size() + m_pend.size();
    m_ok  = 0;
    m_err = 0;
    if (!m_in_frame) begin
      m_idle = 0;
      if (fin && d == SYNC) begin
        m_in_frame = 1;
        m_len      = 0;
        m_pend.delete();
      end
    end else if (fin) begin
      m_idle = 0;
      if (m_len == 0) begin
        if (d >= 1 && int'(d) <= MAX_LEN) m_len = int'(d);
        else model_abort(2'd1);
      end else if (m_pend.size() < m_len) begin
        if (occupied == DEPTH) model_abort(2'd2);
        else m_pend.push_back(d);
      end else begin
        x = 8'(m_len);
        foreach (m_pend[i]) x = x ^ m_pend[i];
        if (x == d) begin
          for (int i = 0; i < m_pend.size(); i++)
            m_commit.push_back({i == m_pend.size() - 1, m_pend[i]});
          m_ok = 1;
          m_pend.delete();
          m_in_frame = 0;
          m_len = 0;
        end else begin
          model_abort(2'd0);
        end
      end
    end else begin
      m_idle++;
      if (m_idle > TIMEOUT) model_abort(2'd3);
    end
    if (do_pop) void'(m_commit.pop_front());
  endtask

  function automatic logic [14:0] model_obs();
    bit         v;
    logic [7:0] dd;
    bit         l;
    v  = m_commit.size() > 0;
    dd = v ? m_commit[0][7:0] : 8'd0;
    l  = v ? m_commit[0][8] : 1'b0;
    return {v, dd, l, m_ok, m_err, m_code, m_in_frame};
  endfunction

  function automatic logic [14:0] dut_obs();
    return {out_valid, out_data, out_last, pkt_ok, pkt_err, err_code, busy};
  endfunction

  function automatic logic [14:0] mk(bit v, logic [7:0] dd, bit l, bit ok, bit er, logic [1:0] c, bit b);
    return {v, dd, l, ok, er, c, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input bit rst, input bit fin, input logic [7:0] d, input bit rdy);
    reset = rst; rx_finish = fin; rx_data = d; out_ready = rdy;
    @(posedge clk);
    model_step(rst, fin, d, rdy);
    @(negedge clk);
    check("model", 32'(dut_obs()), 32'(model_obs()));
    reset = 1'b0; rx_finish = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit rdy);
    cycle(0, 1, d, rdy);
  endtask

  // ---------------- directed table ----------------------------------------
  typedef struct {
    bit          fin;
    logic [7:0]  d;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[64];
  int   nvec;

  task automatic add(input bit fin, input logic [7:0] d, input logic [14:0] exp);
    vecs[nvec] = '{fin, d, exp};
    nvec++;
  endtask

  function automatic bit rnd_rdy();
    return $urandom_range(0, 3) != 0;
  endfunction

  logic [7:0] frame_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  initial begin
    int n;
    bit rdy;
    logic [7:0] x;
    total = 0; bad = 0; nvec = 0;
    reset = 1'b1; rx_finish = 1'b0; rx_data = 8'd0; out_ready = 1'b0;
    @(negedge clk);
    cycle(1, 0, 8'd0, 0);
    cycle(1, 0, 8'd0, 0);
    check("reset_state", 32'(dut_obs()), 32'd0);

    // good frame 11 22 33, consumer always ready
    add(1, 8'h7E, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h03, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h11, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h22, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h33, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h03, mk(1, 8'h11, 0, 1, 0, 2'd0, 0));
    add(0, 8'h00, mk(1, 8'h22, 0, 0, 0, 2'd0, 0));
    add(0, 8'h00, mk(1, 8'h33, 1, 0, 0, 2'd0, 0));
    add(0, 8'h00, mk(0, 8'h00, 0, 0, 0, 2'd0, 0));
    // bad checksum
    add(1, 8'h7E, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h03, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h11, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h22, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h33, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h04, mk(0, 8'h00, 0, 0, 1, 2'd0, 0));
    add(0, 8'h00, mk(0, 8'h00, 0, 0, 0, 2'd0, 0));
    // bad lengths 0 and MAX_LEN+1; following byte parsed in hunt
    add(1, 8'h7E, mk(0, 8'h00, 0, 0, 0, 2'd0, 1));
    add(1, 8'h00, mk(0, 8'h00, 0, 0, 1, 2'd1, 0));
    add(1, 8'h7E, mk(0, 8'h00, 0, 0, 0, 2'd1, 1));
    add(1, 8'h09, mk(0, 8'h00, 0, 0, 1, 2'd1, 0));
    add(1, 8'h03, mk(0, 8'h00, 0, 0, 0, 2'd1, 0));
    // good frame after errors: A5 5A, chk 02^A5^5A = FD
    add(1, 8'h7E, mk(0, 8'h00, 0, 0, 0, 2'd1, 1));
    add(1, 8'h02, mk(0, 8'h00, 0, 0, 0, 2'd1, 1));
    add(1, 8'hA5, mk(0, 8'h00, 0, 0, 0, 2'd1, 1));
    add(1, 8'h5A, mk(0, 8'h00, 0, 0, 0, 2'd1, 1));
    add(1, 8'hFD, mk(1, 8'hA5, 0, 1, 0, 2'd1, 0));
    add(0, 8'h00, mk(1, 8'h5A, 1, 0, 0, 2'd1, 0));
    add(0, 8'h00, mk(0, 8'h00, 0, 0, 0, 2'd1, 0));

    for (int i = 0; i < nvec; i++) begin
      cycle(0, vecs[i].fin, vecs[i].d, 1);
      check("vector", 32'(dut_obs()), 32'(vecs[i].exp));
      $display("vec %0d fin=%0b data=%h -> obs=%h exp=%h", i, vecs[i].fin, vecs[i].d, dut_obs(), vecs[i].exp);
    end

    // overflow: 5 payload bytes into an empty 4-entry FIFO
    foreach (frame_q[i]) frame_q.delete();
    send(8'h7E, 0); send(8'h05, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h05, 0);
    check("ovf_err", {pkt_err, err_code, out_valid}, {1'b1, 2'd2, 1'b0});
    $display("overflow empty fifo: err=%0b code=%0d valid=%0b", pkt_err, err_code, out_valid);
    // committed 2-byte packet survives a later overflow
    send(8'h7E, 0); send(8'h02, 0); send(8'hC1, 0); send(8'hC2, 0); send(8'h01, 0);
    check("commit_c1", {pkt_ok, out_valid, out_data}, {1'b1, 1'b1, 8'hC1});
    send(8'h7E, 0); send(8'h05, 0); send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0);
    check("ovf_keep", {pkt_err, err_code, out_valid, out_data}, {1'b1, 2'd2, 1'b1, 8'hC1});
    cycle(0, 0, 8'd0, 1);
    check("drain_c2", {out_valid, out_data, out_last}, {1'b1, 8'hC2, 1'b1});
    cycle(0, 0, 8'd0, 1);
    check("drain_empty", {31'd0, out_valid}, 32'd0);
    $display("overflow with committed packet: delivered C1 C2");

    // timeout: error lands on the (TIMEOUT+1)th silent cycle
    send(8'h7E, 0); send(8'h02, 0); send(8'hAA, 0);
    n = 0;
    while (n < TIMEOUT + 6) begin
      cycle(0, 0, 8'd0, 0);
      n++;
      if (pkt_err) break;
    end
    check("timeout_cycle", 32'(n), 32'(TIMEOUT + 1));
    check("timeout_code", {pkt_err, err_code, busy}, {1'b1, 2'd3, 1'b0});
    $display("timeout after %0d silent cycles code=%0d", n, err_code);
    // a byte on the expiry cycle is accepted
    send(8'h7E, 0); send(8'h02, 0); send(8'hAA, 0);
    for (int i = 0; i < TIMEOUT; i++) cycle(0, 0, 8'd0, 0);
    send(8'hBB, 0);
    check("expiry_win", {pkt_err, busy}, {1'b0, 1'b1});
    send(8'h13, 0);
    check("expiry_ok", {pkt_ok, out_valid, out_data}, {1'b1, 1'b1, 8'hAA});
    $display("byte on expiry cycle accepted, packet AA BB committed");
    n = 0;
    while (out_valid && n < 20) begin cycle(0, 0, 8'd0, 1); n++; end
    check("drain_done", {31'd0, out_valid}, 32'd0);

    // back-to-back packets with ready toggling every cycle
    frame_q = '{8'h7E, 8'h02, 8'h01, 8'h02, 8'h01, 8'h7E, 8'h02, 8'h04, 8'h05, 8'h03};
    exp_q   = '{8'h01, 8'h02, 8'h04, 8'h05};
    got_q.delete();
    rdy = 0;
    for (int i = 0; i < frame_q.size() + 12; i++) begin
      if (out_valid && rdy) got_q.push_back(out_data);
      if (i < frame_q.size()) cycle(0, 1, frame_q[i], rdy);
      else cycle(0, 0, 8'd0, rdy);
      rdy = !rdy;
    end
    check("bp_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("bp_order", 32'(got_q[i]), 32'(exp_q[i]));
    $display("backpressure: received %0d bytes", got_q.size());

    // reset mid-payload with committed, unread data present
    send(8'h7E, 0); send(8'h01, 0); send(8'h99, 0); send(8'h98, 0);
    send(8'h7E, 0); send(8'h03, 0); send(8'h11, 0);
    check("pre_reset", {out_valid, busy}, {1'b1, 1'b1});
    cycle(1, 0, 8'd0, 0);
    check("mid_reset", 32'(dut_obs()), 32'd0);
    $display("reset mid-payload: outputs cleared");

    // randomized frames against the model
    for (int f = 0; f < 150; f++) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, MAX_LEN);
      frame_q.delete();
      if (kind == 0) begin
        frame_q.push_back(8'($urandom_range(0, 125)));
      end else if (kind == 1) begin
        frame_q.push_back(SYNC);
        frame_q.push_back($urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        frame_q.push_back(SYNC);
        frame_q.push_back(8'(len));
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
          frame_q.push_back(8'($urandom_range(0, 255)));
          x = x ^ frame_q[frame_q.size() - 1];
        end
        if (kind == 2) frame_q.push_back(x ^ 8'($urandom_range(1, 255)));
        else if (kind == 3) void'(frame_q.pop_back());
        else frame_q.push_back(x);
      end
      foreach (frame_q[i]) begin
        send(frame_q[i], rnd_rdy());
        for (int g = $urandom_range(0, 2); g > 0; g--) cycle(0, 0, 8'd0, rnd_rdy());
      end
      if (kind == 3)
        for (int g = 0; g < TIMEOUT + 2; g++) cycle(0, 0, 8'd0, rnd_rdy());
      $display("random frame %0d kind=%0d bytes=%0d ok=%0b err=%0b code=%0d", f, kind, frame_q.size(), pkt_ok, pkt_err, err_code);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
